write_arbiter: RTL and testbench
================================

WRITE_ARBITER -- requirements
Module: write_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter S1_BASE, default 32'h0001_0000, first S1 address; S0 = [0, S1_BASE).
REQ-003 Parameter S1_END, default 32'h0001_FFFF, last S1 address; above is default slave.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 AWVALID_Mx (x=0,1)  in  1  each master's write-address request.
REQ-007 AWADDR_Mx (x=0,1)  in  ADDR_W  each master's write address.
REQ-008 WVALID_Mx, WLAST_Mx, BREADY_Mx (x=0,1)  in  1 each  master W/B handshake signals.
REQ-009 AWREADY_Sy, WREADY_Sy, BVALID_Sy (y=0,1)  in  1 each  slave handshake signals.
REQ-010 aw_grant  out  2  one-hot master owning AW (bit0=M0), 0 = none.
REQ-011 w_grant  out  2  one-hot master owning W.
REQ-012 b_grant  out  2  one-hot master owning B.
REQ-013 slave_sel  out  2  routed slave: 00 S0, 01 S1, 10 default; drives write_slave of the response mux.
REQ-014 def_awready, def_wready, def_bvalid  out  1 each  internal default-slave handshakes.
REQ-015 def_bresp  out  2  default-slave response, constant 2'b11 (DECERR).
REQ-016 busy  out  1  high in any state except IDLE.

Function
REQ-017 FSM states: IDLE, ADDR, DATA, RESP; exactly one write transaction in flight.
REQ-018 IDLE: on any AWVALID, register winner and decoded slave_sel, go to ADDR next cycle; else stay.
REQ-019 Arbitration round-robin: pointer last_m; on simultaneous requests the master != last_m wins; last_m resets to M1, so M0 wins first.
REQ-020 Single request wins regardless of pointer; last_m updated only on exit from RESP.
REQ-021 Decode from registered AWADDR of winner: < S1_BASE -> 00, S1_BASE..S1_END -> 01, else 10.
REQ-022 ADDR: aw_grant = winner; leave to DATA on AWVALID_winner & AWREADY_selected; def_awready = 1 in ADDR when slave_sel=10.
REQ-023 DATA: w_grant = winner; each WVALID & WREADY_selected is a beat; leave to RESP on beat with WLAST_winner; def_wready = 1 in DATA when slave_sel=10.
REQ-024 RESP: b_grant = winner; leave to IDLE on BVALID_selected & BREADY_winner; def_bvalid = 1 in RESP when slave_sel=10.
REQ-025 Grants one-hot or zero, registered; at most one of aw/w/b_grant nonzero per cycle.
REQ-026 slave_sel held constant from ADDR entry to RESP exit; 2'b11 in IDLE.
REQ-027 Request from loser during a transaction is ignored, not queued; re-evaluated in IDLE.
REQ-028 Master dropping AWVALID in ADDR: stay in ADDR (no abort).
REQ-029 Back-to-back: IDLE entry with pending request re-arbitrates next cycle; minimum 4 cycles per single-beat write.
REQ-030 Zero-length hold: WLAST on first beat is legal; DATA lasts one cycle.

Reset
REQ-031 rst high asynchronously forces IDLE, last_m=M1, all grants 0, slave_sel=2'b11, def_* handshakes 0, busy 0.
REQ-032 Reset mid-transaction abandons it; no handshake output asserted in the cycle after release.
REQ-033 First arbitration occurs on the first rising edge after rst deasserts.

Verification
REQ-034 M0 AWADDR=0x0000_0100, single beat, S0 ready -> aw_grant=01, slave_sel=00, 4-cycle IDLE->ADDR->DATA->RESP->IDLE.
REQ-035 M0 and M1 request same cycle, twice -> first grant M0, second grant M1; M1 to 0x0001_0040 gives slave_sel=01.
REQ-036 M1 AWADDR=0x0002_0000, 4 beats -> slave_sel=10, def_awready/def_wready asserted, def_bvalid=1 with def_bresp=11 after WLAST.
REQ-037 S1 WREADY low 3 cycles mid-burst -> FSM stays in DATA, w_grant stable, no beat counted.
REQ-038 BREADY_M0 low 5 cycles in RESP -> b_grant held, M1 request waits, granted cycle after RESP exit.
REQ-039 rst asserted in DATA -> next sample all grants 0, busy 0, slave_sel=11; M0 request after release wins.

Source files
------------

// File: rtl/write_arbiter.sv
// write_arbiter: round-robin two-master write-channel arbiter with address decode and default slave
module write_arbiter #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] S1_BASE = 'h0001_0000,
  parameter logic [ADDR_W-1:0] S1_END  = 'h0001_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AWVALID_M0,
  input  logic              AWVALID_M1,
  input  logic [ADDR_W-1:0] AWADDR_M0,
  input  logic [ADDR_W-1:0] AWADDR_M1,
  input  logic              WVALID_M0,
  input  logic              WVALID_M1,
  input  logic              WLAST_M0,
  input  logic              WLAST_M1,
  input  logic              BREADY_M0,
  input  logic              BREADY_M1,
  input  logic              AWREADY_S0,
  input  logic              AWREADY_S1,
  input  logic              WREADY_S0,
  input  logic              WREADY_S1,
  input  logic              BVALID_S0,
  input  logic              BVALID_S1,
  output logic [1:0]        aw_grant,
  output logic [1:0]        w_grant,
  output logic [1:0]        b_grant,
  output logic [1:0]        slave_sel,
  output logic              def_awready,
  output logic              def_wready,
  output logic              def_bvalid,
  output logic [1:0]        def_bresp,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t            state_q;
  logic              win_q, last_q, win_d;
  logic [1:0]        aw_q, w_q, b_q, sel_q, sel_d;
  logic              def_aw_q, def_w_q, def_b_q, busy_q;
  logic [ADDR_W-1:0] addr_d;
  logic              awvalid, wvalid, wlast, bready, awready, wready, bvalid;
  // arbitration, decode of the would-be winner, and muxing of the current owner's and slave's handshakes
  always_comb begin
    win_d   = (AWVALID_M0 && AWVALID_M1) ? ~last_q : AWVALID_M1;
    addr_d  = win_d ? AWADDR_M1 : AWADDR_M0;
    sel_d   = (addr_d < S1_BASE) ? 2'b00 : (addr_d <= S1_END) ? 2'b01 : 2'b10;
    awvalid = win_q ? AWVALID_M1 : AWVALID_M0;
    wvalid  = win_q ? WVALID_M1 : WVALID_M0;
    wlast   = win_q ? WLAST_M1 : WLAST_M0;
    bready  = win_q ? BREADY_M1 : BREADY_M0;
    awready = (sel_q == 2'b00) ? AWREADY_S0 : (sel_q == 2'b01) ? AWREADY_S1 : def_aw_q;
    wready  = (sel_q == 2'b00) ? WREADY_S0 : (sel_q == 2'b01) ? WREADY_S1 : def_w_q;
    bvalid  = (sel_q == 2'b00) ? BVALID_S0 : (sel_q == 2'b01) ? BVALID_S1 : def_b_q;
  end
  // one transaction at a time: IDLE -> ADDR -> DATA -> RESP, all outputs registered on the transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      aw_q     <= 2'b00;
      w_q      <= 2'b00;
      b_q      <= 2'b00;
      sel_q    <= 2'b11;
      def_aw_q <= 1'b0;
      def_w_q  <= 1'b0;
      def_b_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (AWVALID_M0 || AWVALID_M1) begin
          state_q  <= ADDR;
          win_q    <= win_d;
          aw_q     <= win_d ? 2'b10 : 2'b01;
          sel_q    <= sel_d;
          def_aw_q <= sel_d == 2'b10;
          busy_q   <= 1'b1;
        end
        ADDR: if (awvalid && awready) begin
          state_q  <= DATA;
          aw_q     <= 2'b00;
          w_q      <= aw_q;
          def_aw_q <= 1'b0;
          def_w_q  <= sel_q == 2'b10;
        end
        DATA: if (wvalid && wready && wlast) begin
          state_q <= RESP;
          w_q     <= 2'b00;
          b_q     <= w_q;
          def_w_q <= 1'b0;
          def_b_q <= sel_q == 2'b10;
        end
        RESP: if (bvalid && bready) begin
          state_q <= IDLE;
          b_q     <= 2'b00;
          def_b_q <= 1'b0;
          sel_q   <= 2'b11;
          last_q  <= win_q;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign aw_grant    = aw_q;
  assign w_grant     = w_q;
  assign b_grant     = b_q;
  assign slave_sel   = sel_q;
  assign def_awready = def_aw_q;
  assign def_wready  = def_w_q;
  assign def_bvalid  = def_b_q;
  assign def_bresp   = 2'b11;
  assign busy        = busy_q;
endmodule

// File: tb/tb_write_arbiter.sv
// tb_write_arbiter: directed scenarios checked against a transaction-level model every cycle
module tb_write_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  awv = 2'b00, wv = 2'b11, wl = 2'b11, br = 2'b11;
  logic [1:0]  awr = 2'b11, wr = 2'b11, bv = 2'b11;
  logic [31:0] a0 = '0, a1 = '0;
  logic [1:0]  aw_grant, w_grant, b_grant, slave_sel, def_bresp;
  logic        def_awready, def_wready, def_bvalid, busy;
  int          n_vec = 0, n_err = 0;
  int          ph = 0, own = 0, last_m = 1, beats = 0;
  logic [1:0]  msel = 2'b11;

  write_arbiter dut (
    .clk(clk), .rst(rst),
    .AWVALID_M0(awv[0]), .AWVALID_M1(awv[1]),
    .AWADDR_M0(a0), .AWADDR_M1(a1),
    .WVALID_M0(wv[0]), .WVALID_M1(wv[1]),
    .WLAST_M0(wl[0]), .WLAST_M1(wl[1]),
    .BREADY_M0(br[0]), .BREADY_M1(br[1]),
    .AWREADY_S0(awr[0]), .AWREADY_S1(awr[1]),
    .WREADY_S0(wr[0]), .WREADY_S1(wr[1]),
    .BVALID_S0(bv[0]), .BVALID_S1(bv[1]),
    .aw_grant(aw_grant), .w_grant(w_grant), .b_grant(b_grant),
    .slave_sel(slave_sel), .def_awready(def_awready), .def_wready(def_wready),
    .def_bvalid(def_bvalid), .def_bresp(def_bresp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] dec(input logic [31:0] a);
    return (a < 32'h0001_0000) ? 2'd0 : (a <= 32'h0001_FFFF) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic rdy(input logic [1:0] s, input logic [1:0] v);
    return (s == 2'd2) ? 1'b1 : v[s[0]];
  endfunction

  // model: phase 0 idle, 1 address, 2 data, 3 response; owner and slave fixed per transaction
  always @(posedge clk) begin
    logic [1:0] oh;
    if (rst) begin
      ph = 0; last_m = 1; own = 0; msel = 2'b11; beats = 0;
    end else if (ph == 0) begin
      if (awv != 2'b00) begin
        own  = (awv == 2'b11) ? 1 - last_m : (awv[1] ? 1 : 0);
        msel = dec(own == 1 ? a1 : a0);
        ph = 1; beats = 0;
      end
    end else if (ph == 1) begin
      if (awv[own] && rdy(msel, awr)) ph = 2;
    end else if (ph == 2) begin
      if (wv[own] && rdy(msel, wr)) begin
        beats++;
        if (wl[own]) ph = 3;
      end
    end else if (br[own] && rdy(msel, bv)) begin
      ph = 0; last_m = own;
    end
    #1;
    oh = (own == 1) ? 2'b10 : 2'b01;
    chk("aw_grant", aw_grant, ph == 1 ? oh : 2'b00);
    chk("w_grant", w_grant, ph == 2 ? oh : 2'b00);
    chk("b_grant", b_grant, ph == 3 ? oh : 2'b00);
    chk("slave_sel", slave_sel, ph == 0 ? 2'b11 : msel);
    chk("def_awready", def_awready, ph == 1 && msel == 2'd2);
    chk("def_wready", def_wready, ph == 2 && msel == 2'd2);
    chk("def_bvalid", def_bvalid, ph == 3 && msel == 2'd2);
    chk("def_bresp", def_bresp, 2'b11);
    chk("busy", busy, ph != 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) cyc(1);
    chk("idle_wait", busy, 0);
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("rst_aw", aw_grant, 2'b00);
    chk("rst_sel", slave_sel, 2'b11);
    chk("rst_busy", busy, 0);
    // single-beat write from M0 to S0 takes exactly four cycles
    awv = 2'b01; a0 = 32'h0000_0100;
    cyc(1); chk("s1_aw", aw_grant, 2'b01); chk("s1_sel", slave_sel, 2'b00); chk("s1_busy", busy, 1);
    cyc(1); chk("s1_w", w_grant, 2'b01); awv = 2'b00;
    cyc(1); chk("s1_b", b_grant, 2'b01);
    cyc(1); chk("s1_idle", busy, 0); chk("s1_sel_idle", slave_sel, 2'b11);
    // simultaneous requests alternate, starting with M0 after reset
    rst = 1'b1; cyc(1); rst = 1'b0;
    awv = 2'b11; a0 = 32'h0000_0200; a1 = 32'h0001_0040;
    cyc(1); chk("s2_first", aw_grant, 2'b01); chk("s2_sel0", slave_sel, 2'b00);
    cyc(4); chk("s2_second", aw_grant, 2'b10); chk("s2_sel1", slave_sel, 2'b01);
    cyc(1); awv = 2'b00;
    wait_idle();
    // four-beat burst from M1 to the default slave
    awv = 2'b10; a1 = 32'h0002_0000; wl = 2'b01;
    cyc(1); chk("s3_aw", aw_grant, 2'b10); chk("s3_sel", slave_sel, 2'b10); chk("s3_defaw", def_awready, 1);
    cyc(1); chk("s3_w", w_grant, 2'b10); chk("s3_defw", def_wready, 1); awv = 2'b00;
    cyc(3); chk("s3_w_held", w_grant, 2'b10); wl = 2'b11;
    cyc(1); chk("s3_b", b_grant, 2'b10); chk("s3_defb", def_bvalid, 1); chk("s3_bresp", def_bresp, 2'b11);
    chk("s3_beats", beats, 4);
    cyc(1); chk("s3_idle", busy, 0);
    // S1 WREADY stalls three cycles mid-burst; lowest S1 address decodes to S1
    awv = 2'b01; a0 = 32'h0001_0000; wl = 2'b10;
    cyc(1); chk("s4_sel", slave_sel, 2'b01);
    cyc(1); awv = 2'b00;
    cyc(1); wr = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cyc(1); chk("s4_stall_w", w_grant, 2'b01);
    end
    chk("s4_stall_beats", beats, 1);
    wr = 2'b11;
    cyc(2); wl = 2'b11;
    cyc(1); chk("s4_b", b_grant, 2'b01); chk("s4_beats", beats, 4);
    wait_idle();
    // M0 holds BREADY low in RESP while M1 waits; highest S0 address decodes to S0
    awv = 2'b01; a0 = 32'h0000_FFFF; br = 2'b10;
    cyc(1); chk("s5_aw", aw_grant, 2'b01); chk("s5_sel", slave_sel, 2'b00);
    cyc(1); awv = 2'b10; a1 = 32'h0001_0040;
    cyc(1); chk("s5_b", b_grant, 2'b01);
    for (int i = 0; i < 5; i++) begin
      cyc(1); chk("s5_b_held", b_grant, 2'b01); chk("s5_no_aw", aw_grant, 2'b00);
    end
    br = 2'b11;
    cyc(1); chk("s5_exit", busy, 0); chk("s5_exit_aw", aw_grant, 2'b00);
    cyc(1); chk("s5_m1", aw_grant, 2'b10); chk("s5_m1_sel", slave_sel, 2'b01);
    cyc(1); awv = 2'b00;
    wait_idle();
    // reset in DATA abandons the write; M0 wins the first arbitration afterwards
    awv = 2'b01; a0 = 32'h0000_0300; wl = 2'b10;
    cyc(2); awv = 2'b00; chk("s6_data", w_grant, 2'b01);
    rst = 1'b1; #1; chk("s6_async_w", w_grant, 2'b00);
    cyc(1);
    chk("s6_aw", aw_grant, 2'b00); chk("s6_w", w_grant, 2'b00); chk("s6_b", b_grant, 2'b00);
    chk("s6_busy", busy, 0); chk("s6_sel", slave_sel, 2'b11);
    rst = 1'b0; awv = 2'b11; a1 = 32'h0001_0040; #1;
    chk("s6_rel_aw", aw_grant, 2'b00); chk("s6_rel_defaw", def_awready, 0);
    cyc(1); chk("s6_m0", aw_grant, 2'b01); chk("s6_m0_sel", slave_sel, 2'b00);
    cyc(1); awv = 2'b00; wl = 2'b11;
    wait_idle();
    cyc(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
